// File: rtl/rv32i_types.sv
// Shared types and defaults for the data memory responder.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_LATENCY_DEF = 2;
  localparam int DMEM_DEPTH_DEF   = 256;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one synchronous byte-masked write port, one combinational read port.
module dmem_array
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [3:0]      wmask,
  input  logic [AW-1:0]   widx,
  input  rv32i_word       wdata,
  input  logic [AW-1:0]   ridx,
  output rv32i_word       rdata
);

  rv32i_word mem [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the MEM stage: IDLE/BUSY/RESP handshake over dmem_array.
// Optional macro DMEM_ADDR_CHECK_EN adds err_b and blocks accesses above the storage range.
module data_mem_responder
  import rv32i_types::*;
#(
  parameter int LATENCY     = DMEM_LATENCY_DEF,
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  rv32i_word   address_b,
  input  rv32i_word   wdata,
  output logic        resp_b,
  output rv32i_word   rdata_b
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic        err_b
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_t   state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  rv32i_word     wdata_q;
  logic [3:0]    wmask_q;
  logic          op_read_q;
  logic          op_write_q;
  logic          addr_hi_q;
  logic          resp_q;

  logic          req;
  logic          addr_err;
  logic          mem_we;
  rv32i_word     mem_rdata;
  logic          unused_bits;

  assign req = read_b | write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_hi_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          if (req) begin
            idx_q      <= address_b[AW+1:2];
            addr_hi_q  <= |address_b[31:AW+2];
            wdata_q    <= wdata;
            wmask_q    <= wmask;
            op_read_q  <= read_b;
            op_write_q <= write;
            cnt        <= CNT_LOAD;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // Counter holds the BUSY cycles still to run, so the last one hands over to RESP.
          if (cnt <= 4'd1) begin
            cnt    <= '0;
            state  <= RESP;
            resp_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          resp_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          resp_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_err    = addr_hi_q;
  assign err_b       = resp_q & addr_hi_q;
  assign unused_bits = ^address_b[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_bits = ^{address_b[1:0], addr_hi_q};
`endif

  // Commit at the end of RESP so a combined read/write still sees the old word; a reset here aborts it.
  assign mem_we = (state == RESP) & op_write_q & ~addr_err & ~rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wmask (wmask_q),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (idx_q),
    .rdata (mem_rdata)
  );

  assign resp_b  = resp_q;
  assign rdata_b = (resp_q & op_read_q & ~addr_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2, DEPTH_WORDS=256 (honours DMEM_ADDR_CHECK_EN).
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        err_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .LATENCY(LAT),
    .DEPTH_WORDS(256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read_b    (read_b),
    .write     (write),
    .wmask     (wmask),
    .address_b (address_b),
    .wdata     (wdata),
    .resp_b    (resp_b),
    .rdata_b   (rdata_b)
`ifdef DMEM_ADDR_CHECK_EN
    ,
    .err_b     (err_b)
`endif
  );

`ifndef DMEM_ADDR_CHECK_EN
  assign err_b = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request, held until resp_b; inputs are driven and outputs sampled on the falling edge.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] wm,
                     output logic [31:0] rdata, output logic err);
    int  n;
    logic got, quiet;
    @(negedge clk);
    read_b = rd; write = wr; address_b = addr; wdata = wd; wmask = wm;
    n = 0; got = 1'b0; quiet = 1'b1;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (resp_b) got = 1'b1;
      else if (rdata_b != 32'h0 || err_b) quiet = 1'b0;
    end
    rdata = rdata_b;
    err   = err_b;
    read_b = 1'b0; write = 1'b0;
    check("latency", n, LAT);
    check("quiet_before_resp", {31'b0, quiet}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd_v;
    logic        er_v;
    logic        ok;
    int          prev, pulses, n;

    vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBEAA};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 32'hDEADBEAA};
    vecs[6]  = '{1'b1, 1'b0, 32'h13, 32'h0,        4'b0000, 1'b1, 32'hDEADBEAA};
    vecs[7]  = '{1'b0, 1'b1, 32'h40, 32'h11111111, 4'b1111, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h40, 32'h22222222, 4'b1111, 1'b1, 32'h11111111};
    vecs[9]  = '{1'b1, 1'b0, 32'h40, 32'h0,        4'b0000, 1'b1, 32'h22222222};
    vecs[10] = '{1'b0, 1'b1, 32'h44, 32'h00000000, 4'b1111, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 4'b1010, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h44, 32'h0,        4'b0000, 1'b1, 32'hA500A500};

    rst = 1'b1; read_b = 1'b0; write = 1'b0; wmask = '0; address_b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_resp", {31'b0, resp_b}, 32'd0);
    check("reset_rdata", rdata_b, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].wm, rd_v, er_v);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp);
    end

    // Single pulse: resp_b drops right after RESP.
    @(negedge clk);
    check("resp_one_cycle", {31'b0, resp_b}, 32'd0);

    // Held read: a response every LAT+1 cycles, rdata_b zero in between.
    txn(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd_v, er_v);
    @(negedge clk);
    read_b = 1'b1; address_b = 32'h20;
    prev = -1; pulses = 0;
    for (int i = 1; i <= 30 && pulses < 4; i++) begin
      @(negedge clk);
      if (resp_b) begin
        check("held_rdata", rdata_b, 32'hCAFEF00D);
        if (prev >= 0) check("held_period", i - prev, LAT + 1);
        prev = i;
        pulses++;
        if (pulses == 4) read_b = 1'b0;
      end else if (rdata_b != 32'h0) begin
        check("held_rdata_gap", rdata_b, 32'h0);
      end
    end
    read_b = 1'b0;
    check("held_pulses", pulses, 4);

    // Reset while BUSY aborts the write and never pulses resp_b.
    txn(1'b0, 1'b1, 32'h30, 32'h55AA55AA, 4'b1111, rd_v, er_v);
    @(negedge clk);
    write = 1'b1; address_b = 32'h30; wdata = 32'h12345678; wmask = 4'b1111;
    @(negedge clk);
    check("busy_no_resp", {31'b0, resp_b}, 32'd0);
    rst = 1'b1; write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_b) ok = 1'b0;
    end
    check("abort_no_resp", {31'b0, ok}, 32'd1);
    txn(1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, rd_v, er_v);
    check("abort_busy_kept", rd_v, 32'h55AA55AA);

    // Reset during RESP blocks the commit.
    txn(1'b0, 1'b1, 32'h34, 32'h0BADF00D, 4'b1111, rd_v, er_v);
    @(negedge clk);
    write = 1'b1; address_b = 32'h34; wdata = 32'hFFFFFFFF; wmask = 4'b1111;
    n = 0;
    while (n < 20 && !resp_b) begin
      @(negedge clk);
      n++;
    end
    check("resp_rst_latency", n, LAT);
    rst = 1'b1; write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    txn(1'b1, 1'b0, 32'h34, 32'h0, 4'b0000, rd_v, er_v);
    check("abort_resp_kept", rd_v, 32'h0BADF00D);

    // Address above the storage range: aliases to word 0, or flagged and blocked.
    txn(1'b0, 1'b1, 32'h0, 32'h13579BDF, 4'b1111, rd_v, er_v);
    check("err_in_range", {31'b0, er_v}, 32'd0);
    txn(1'b0, 1'b1, 32'h400, 32'h2468ACE0, 4'b1111, rd_v, er_v);
`ifdef DMEM_ADDR_CHECK_EN
    check("err_oob_write", {31'b0, er_v}, 32'd1);
    txn(1'b1, 1'b0, 32'h400, 32'h0, 4'b0000, rd_v, er_v);
    check("err_oob_read", {31'b0, er_v}, 32'd1);
    check("oob_read_zero", rd_v, 32'h0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, rd_v, er_v);
    check("word0_unchanged", rd_v, 32'h13579BDF);
`else
    check("err_oob_write", {31'b0, er_v}, 32'd0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, rd_v, er_v);
    check("word0_aliased", rd_v, 32'h2468ACE0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from request acceptance to resp_b; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port read_b, input, 1: read request from the MEM stage.
REQ-006 SHALL have port write, input, 1: write request from the MEM stage.
REQ-007 SHALL have port wmask, input, 4: byte enables for write; bit i enables wdata byte i.
REQ-008 SHALL have port address_b, input, 32 (rv32i_word): byte address.
REQ-009 SHALL have port wdata, input, 32 (rv32i_word): write data.
REQ-010 SHALL have port resp_b, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rdata_b, output, 32 (rv32i_word): read data, valid only while resp_b=1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-013 IDLE: request = read_b|write; on request, latch address, wdata, wmask, op; load counter with LATENCY-1; go to BUSY, or to RESP directly if LATENCY=1.
REQ-014 BUSY: decrement counter each cycle; at 0 go to RESP; inputs ignored, latched copies used.
REQ-015 RESP: resp_b=1 for exactly this cycle; next state is IDLE unconditionally.
REQ-016 Request accepted in IDLE at cycle t SHALL produce resp_b at cycle t+LATENCY.
REQ-017 SHALL return to IDLE for one cycle between responses; held request is re-accepted one cycle after resp_b, and the initiator deasserts it on resp_b.
REQ-018 Word index = latched address[log2(DEPTH_WORDS)+1:2]; address[1:0] ignored; upper bits wrap (alias).
REQ-019 Write SHALL commit in the RESP cycle, updating only bytes with wmask=1; wmask=0000 SHALL complete with resp_b but change no storage.
REQ-020 Read SHALL drive rdata_b with the stored word in the RESP cycle; rdata_b=0 whenever resp_b=0.
REQ-021 read_b and write both high: treat as write; rdata_b returns the word's pre-write contents.
REQ-022 Back-to-back write then read of the same word SHALL return the newly written bytes.

Reset
REQ-023 rst=1 SHALL force state IDLE, counter 0, resp_b 0, rdata_b 0, latched request cleared.
REQ-024 Reset in BUSY or RESP SHALL abort the transaction; a pending write SHALL NOT commit and no resp_b is issued.
REQ-025 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro DMEM_ADDR_CHECK_EN defined: output port err_b, 1 bit, SHALL pulse with resp_b when latched address[31:log2(DEPTH_WORDS)+2] is nonzero; such writes SHALL be suppressed and such reads SHALL return 0.
REQ-027 Macro undefined: no err_b port; out-of-range addresses alias per REQ-018.

Structure
REQ-028 State enum dmem_state_t and default constants DMEM_LATENCY_DEF and DMEM_DEPTH_DEF SHALL live in package rv32i_types; rv32i_word taken from it.
REQ-029 Storage SHALL be sub-module dmem_array: one synchronous byte-masked write port, one combinational read port; the FSM and counter stay in data_mem_responder.

Verification
REQ-030 LATENCY=2: write 0xDEADBEEF to 0x10, wmask 1111, accepted cycle 5 -> resp_b exactly at cycle 7 only; read of 0x10 returns 0xDEADBEEF.
REQ-031 Word 0x10=0xDEADBEEF; write 0x000000AA, wmask 0001 -> read of 0x10 returns 0xDEADBEAA; wmask 0000 -> unchanged.
REQ-032 Hold read_b=1 continuously at 0x20 -> resp_b every LATENCY+1 cycles (every 3 at LATENCY=2); rdata_b=0 between pulses.
REQ-033 Write 0x12345678 to 0x30; assert rst in BUSY -> no resp_b; read of 0x30 returns old contents.
REQ-034 read_b=write=1 at 0x40 holding 0x11111111, wdata 0x22222222 -> rdata_b 0x11111111; next read returns 0x22222222.
REQ-035 DMEM_ADDR_CHECK_EN, DEPTH_WORDS=256: write to 0x400 -> err_b=1 with resp_b, word 0 unchanged; without the macro, the write lands in word 0.
